// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the multi-channel clock-enable generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: div_t (divisor at the default 8-bit width), MinDiv (smallest legal
// divisor), sel_width() (channel-select width, never less than one bit).
package clkdiv_pkg;

  localparam int DefaultDivWidth = 8;
  localparam int MinDiv          = 2;

  typedef logic [DefaultDivWidth-1:0] div_t;

  function automatic int sel_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: phase counter, pending divisor and registered strobes.
// Latency: one cycle from en rise, sync or a restart write to phase 0.
// Backpressure: none; writes are always accepted, and the last write wins.
// Ports: clk, rst (sync, active-high), en, sync, wr/wr_val (pre-validated
// divisor write), busy, clk_pos, clk_neg, clk_out (all flop outputs).
module clock_divider_channel
  import clkdiv_pkg::*;
#(
  parameter int DivWidth   = 8,
  parameter int DefaultDiv = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                sync,
  input  logic                wr,
  input  logic [DivWidth-1:0] wr_val,
  output logic                busy,
  output logic                clk_pos,
  output logic                clk_neg,
  output logic                clk_out
);

  localparam logic [DivWidth-1:0] One = DivWidth'(1);

  logic [DivWidth-1:0] n_q, n_d;
  logic [DivWidth-1:0] pend_val_q, pend_val_d;
  logic                pend_q, pend_d;
  logic [DivWidth-1:0] phase_q, phase_d;
  logic                run_q, run_d;
  logic                restart;
  logic [DivWidth:0]   n_sum;
  logic [DivWidth-1:0] half_d;

  always_comb begin
    n_d        = n_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    phase_d    = phase_q;
    run_d      = run_q;
    restart    = 1'b0;

    if (!en) begin
      // Idle: nothing to keep glitch-free, so a pending divisor lands at once.
      run_d   = 1'b0;
      phase_d = '0;
      if (pend_q) begin
        n_d    = pend_val_q;
        pend_d = 1'b0;
      end
    end else if (!run_q || sync) begin
      // First cycle after reset or en rise, or a forced restart: phase 0.
      run_d   = 1'b1;
      phase_d = '0;
      restart = 1'b1;
      if (pend_q) begin
        n_d    = pend_val_q;
        pend_d = 1'b0;
      end
    end else if (phase_q == n_q - One) begin
      phase_d = '0;
      if (pend_q) begin
        n_d    = pend_val_q;
        pend_d = 1'b0;
      end
    end else begin
      phase_d = phase_q + One;
    end

    // A write coinciding with a restart defines the restarted period directly;
    // otherwise it waits for the next period boundary.
    if (wr) begin
      if (restart) begin
        n_d    = wr_val;
        pend_d = 1'b0;
      end else begin
        pend_val_d = wr_val;
        pend_d     = 1'b1;
      end
    end

    // High-phase length H = ceil(N/2), one extra bit so N = 2**DivWidth-1 fits.
    n_sum  = {1'b0, n_d} + {{DivWidth{1'b0}}, 1'b1};
    half_d = n_sum[DivWidth:1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q        <= DivWidth'(DefaultDiv);
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      phase_q    <= '0;
      run_q      <= 1'b0;
      busy       <= 1'b0;
      clk_pos    <= 1'b0;
      clk_neg    <= 1'b0;
      clk_out    <= 1'b1;
    end else begin
      n_q        <= n_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      phase_q    <= phase_d;
      run_q      <= run_d;
      busy       <= pend_d;
      if (run_d) begin
        clk_pos <= (phase_d == '0);
        clk_neg <= (phase_d == half_d);
        clk_out <= (phase_d < half_d);
      end else begin
        clk_pos <= 1'b0;
        clk_neg <= 1'b0;
        clk_out <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock-enable generator with glitch-free divisor updates.
// Latency: one cycle from en rise or sync to clk_pos; divisor writes show on busy after one cycle.
// Backpressure: none; invalid divisors pulse div_err, and out-of-range selects are dropped.
// Ports: clk, rst (sync, active-high), en[Channels], sync, div_wr/div_sel/div_val,
// div_err, busy/clk_pos/clk_neg/clk_out[Channels] (all flop outputs).
module clock_divider_multi
  import clkdiv_pkg::*;
#(
  parameter int  Channels   = 4,
  parameter int  DivWidth   = 8,
  parameter int  DefaultDiv = 2,
  localparam int SelW       = sel_width(Channels)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [Channels-1:0] en,
  input  logic                sync,
  input  logic                div_wr,
  input  logic [SelW-1:0]     div_sel,
  input  logic [DivWidth-1:0] div_val,
  output logic                div_err,
  output logic [Channels-1:0] busy,
  output logic [Channels-1:0] clk_pos,
  output logic [Channels-1:0] clk_neg,
  output logic [Channels-1:0] clk_out
);

  logic                val_ok;
  logic [Channels-1:0] ch_wr;

  assign val_ok = (div_val >= DivWidth'(MinDiv));

  // A rejected divisor is reported even when the select is out of range.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_err <= 1'b0;
    end else begin
      div_err <= div_wr && !val_ok;
    end
  end

  for (genvar i = 0; i < Channels; i++) begin : g_ch
    assign ch_wr[i] = div_wr && val_ok && (div_sel == SelW'(i));

    clock_divider_channel #(
      .DivWidth  (DivWidth),
      .DefaultDiv(DefaultDiv)
    ) u_channel (
      .clk    (clk),
      .rst    (rst),
      .en     (en[i]),
      .sync   (sync),
      .wr     (ch_wr[i]),
      .wr_val (div_val),
      .busy   (busy[i]),
      .clk_pos(clk_pos[i]),
      .clk_neg(clk_neg[i]),
      .clk_out(clk_out[i])
    );
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi, configured with five channels so that
// div_sel = 5 is a representable, out-of-range select.
module tb_clock_divider_multi;

  localparam int Channels   = 5;
  localparam int DivWidth   = 8;
  localparam int DefaultDiv = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] en;
  logic       sync;
  logic       div_wr;
  logic [2:0] div_sel;
  logic [7:0] div_val;
  logic       div_err;
  logic [4:0] busy, clk_pos, clk_neg, clk_out;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  clock_divider_multi #(
    .Channels  (Channels),
    .DivWidth  (DivWidth),
    .DefaultDiv(DefaultDiv)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .sync   (sync),
    .div_wr (div_wr),
    .div_sel(div_sel),
    .div_val(div_val),
    .div_err(div_err),
    .busy   (busy),
    .clk_pos(clk_pos),
    .clk_neg(clk_neg),
    .clk_out(clk_out)
  );

  // Advance one edge; outputs are then sampled 1 time unit after that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 5'b11111; sync = 1'b0;
    div_wr = 1'b0; div_sel = 3'd0; div_val = 8'd0;
    tick(); tick();
    nvec++;
    if ({clk_out, clk_pos, clk_neg, busy, div_err} !== {5'b11111, 5'b00000, 5'b00000, 5'b00000, 1'b0}) begin
      nerr++;
      $display("FAIL reset_values got out=%b pos=%b neg=%b busy=%b err=%b want out=11111 pos=0 neg=0 busy=0 err=0",
               clk_out, clk_pos, clk_neg, busy, div_err);
    end
  endtask

  // N=2 from reset: phase 0 on the first post-reset cycle, then alternating.
  task automatic test_default_div();
    logic [14:0] expv;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      expv = (k % 2 == 0) ? {5'b11111, 5'b11111, 5'b00000} : {5'b00000, 5'b00000, 5'b11111};
      nvec++;
      if ({clk_out, clk_pos, clk_neg} !== expv) begin
        nerr++;
        $display("FAIL default_div cyc%0d got %b want %b", k, {clk_out, clk_pos, clk_neg}, expv);
      end
    end
  endtask

  // N=5 written to ch1 during phase 0 of an N=2 period.
  task automatic test_write_mid_period();
    logic [3:0] expv;
    logic       ph_even;
    int         ph;
    sync = 1'b1; tick(); sync = 1'b0;
    nvec++;
    if (clk_pos !== 5'b11111) begin
      nerr++;
      $display("FAIL wr_sync_pos got %b want 11111", clk_pos);
    end
    div_wr = 1'b1; div_sel = 3'd1; div_val = 8'd5;
    tick();
    div_wr = 1'b0;
    nvec++;
    if ({busy, clk_out[1], clk_pos[1], clk_neg[1]} !== {5'b00010, 3'b001}) begin
      nerr++;
      $display("FAIL wr_old_period got busy=%b ch1=%b want busy=00010 ch1=001",
               busy, {clk_out[1], clk_pos[1], clk_neg[1]});
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      ph      = k % 5;
      ph_even = (k % 2 == 0);
      expv    = {ph < 3, ph == 0, ph == 3, 1'b0};
      nvec++;
      if ({clk_out[1], clk_pos[1], clk_neg[1], busy[1]} !== expv || clk_out[0] !== ph_even) begin
        nerr++;
        $display("FAIL wr_n5 cyc%0d got ch1(out,pos,neg,busy)=%b ch0out=%b want %b ch0out=%b",
                 k, {clk_out[1], clk_pos[1], clk_neg[1], busy[1]}, clk_out[0], expv, ph_even);
      end
    end
  endtask

  task automatic test_div_errors();
    logic [4:0] expv;
    div_wr = 1'b1; div_sel = 3'd1; div_val = 8'd1;
    tick();
    div_wr = 1'b0;
    nvec++;
    if ({div_err, busy} !== {1'b1, 5'b00000}) begin
      nerr++;
      $display("FAIL err_n1 got err=%b busy=%b want err=1 busy=00000", div_err, busy);
    end
    tick();
    nvec++;
    if (div_err !== 1'b0) begin
      nerr++;
      $display("FAIL err_single_pulse got %b want 0", div_err);
    end
    div_wr = 1'b1; div_sel = 3'd2; div_val = 8'd0;
    tick();
    nvec++;
    if (div_err !== 1'b1) begin
      nerr++;
      $display("FAIL err_n0 got %b want 1", div_err);
    end
    div_sel = 3'd5; div_val = 8'd3;
    tick();
    div_wr = 1'b0;
    nvec++;
    if ({div_err, busy} !== {1'b0, 5'b00000}) begin
      nerr++;
      $display("FAIL sel_oob got err=%b busy=%b want err=0 busy=00000", div_err, busy);
    end
    tick();
    nvec++;
    if (busy !== 5'b00000) begin
      nerr++;
      $display("FAIL sel_oob_busy got %b want 00000", busy);
    end
    // Divisors must still be ch1=5, all others 2.
    sync = 1'b1; tick(); sync = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick();
      expv    = (k % 2 == 0) ? 5'b11101 : 5'b00000;
      expv[1] = (k % 5 == 0);
      nvec++;
      if (clk_pos !== expv) begin
        nerr++;
        $display("FAIL err_div_kept cyc%0d got pos=%b want %b", k, clk_pos, expv);
      end
    end
  endtask

  // Channels 0..2 at N=3,4,7; sync aligns them and the periods are then checked.
  task automatic test_sync_align();
    int         nt[5] = '{3, 4, 7, 2, 2};
    int         ht[5] = '{2, 2, 4, 1, 1};
    int         ph;
    logic [4:0] eo, ep, eg;
    div_wr = 1'b1;
    div_sel = 3'd0; div_val = 8'd3; tick();
    div_sel = 3'd1; div_val = 8'd4; tick();
    div_sel = 3'd2; div_val = 8'd7; tick();
    div_wr = 1'b0;
    for (int k = 0; k < 13; k++) tick();
    nvec++;
    if (busy !== 5'b00000) begin
      nerr++;
      $display("FAIL sync_busy_settled got %b want 00000", busy);
    end
    sync = 1'b1; tick(); sync = 1'b0;
    nvec++;
    if ({clk_pos, clk_out, clk_neg} !== {5'b11111, 5'b11111, 5'b00000}) begin
      nerr++;
      $display("FAIL sync_aligned got pos=%b out=%b neg=%b want pos=11111 out=11111 neg=00000",
               clk_pos, clk_out, clk_neg);
    end
    for (int k = 1; k < 14; k++) begin
      tick();
      for (int i = 0; i < 5; i++) begin
        ph    = k % nt[i];
        eo[i] = (ph < ht[i]);
        ep[i] = (ph == 0);
        eg[i] = (ph == ht[i]);
      end
      nvec++;
      if ({clk_out, clk_pos, clk_neg} !== {eo, ep, eg}) begin
        nerr++;
        $display("FAIL sync_periods cyc%0d got out=%b pos=%b neg=%b want out=%b pos=%b neg=%b",
                 k, clk_out, clk_pos, clk_neg, eo, ep, eg);
      end
    end
  endtask

  // ch2 at N=7: writes of 6 then 9 while busy, then a write coinciding with sync.
  task automatic test_back_to_back();
    logic [3:0] expv;
    logic [2:0] exp3;
    int         ph;
    sync = 1'b1; tick(); sync = 1'b0;
    div_wr = 1'b1; div_sel = 3'd2; div_val = 8'd6;
    for (int p = 1; p < 7; p++) begin
      if (p == 2) div_val = 8'd9;
      if (p == 3) div_wr = 1'b0;
      tick();
      expv = {p < 4, 1'b0, p == 4, 1'b1};
      nvec++;
      if ({clk_out[2], clk_pos[2], clk_neg[2], busy[2]} !== expv) begin
        nerr++;
        $display("FAIL b2b_old_n7 ph%0d got %b want %b", p,
                 {clk_out[2], clk_pos[2], clk_neg[2], busy[2]}, expv);
      end
    end
    div_wr = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      ph   = k % 9;
      expv = {ph < 5, ph == 0, ph == 5, 1'b0};
      nvec++;
      if ({clk_out[2], clk_pos[2], clk_neg[2], busy[2]} !== expv) begin
        nerr++;
        $display("FAIL b2b_n9 cyc%0d got %b want %b", k,
                 {clk_out[2], clk_pos[2], clk_neg[2], busy[2]}, expv);
      end
    end
    div_wr = 1'b1; div_sel = 3'd2; div_val = 8'd4; sync = 1'b1;
    tick();
    div_wr = 1'b0; sync = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      ph   = k % 4;
      exp3 = {ph < 2, ph == 0, ph == 2};
      nvec++;
      if ({clk_out[2], clk_pos[2], clk_neg[2]} !== exp3) begin
        nerr++;
        $display("FAIL wr_sync_n4 cyc%0d got %b want %b", k,
                 {clk_out[2], clk_pos[2], clk_neg[2]}, exp3);
      end
    end
  endtask

  // ch0 at N=3: drop en mid-high, write while idle, re-enable.
  task automatic test_enable();
    logic [2:0] exp3;
    int         ph;
    sync = 1'b1; tick(); sync = 1'b0;
    tick();
    nvec++;
    if ({clk_out[0], clk_pos[0], clk_neg[0]} !== 3'b100) begin
      nerr++;
      $display("FAIL en_pre_drop got %b want 100", {clk_out[0], clk_pos[0], clk_neg[0]});
    end
    en[0] = 1'b0;
    tick();
    nvec++;
    if ({clk_out[0], clk_pos[0], clk_neg[0]} !== 3'b100) begin
      nerr++;
      $display("FAIL en_idle got %b want 100", {clk_out[0], clk_pos[0], clk_neg[0]});
    end
    div_wr = 1'b1; div_sel = 3'd0; div_val = 8'd5;
    tick();
    div_wr = 1'b0;
    nvec++;
    if ({busy[0], clk_out[0], clk_pos[0], clk_neg[0]} !== 4'b1100) begin
      nerr++;
      $display("FAIL en_idle_wr got busy,out,pos,neg=%b want 1100",
               {busy[0], clk_out[0], clk_pos[0], clk_neg[0]});
    end
    tick();
    nvec++;
    if ({busy[0], clk_out[0], clk_pos[0], clk_neg[0]} !== 4'b0100) begin
      nerr++;
      $display("FAIL en_idle_apply got busy,out,pos,neg=%b want 0100",
               {busy[0], clk_out[0], clk_pos[0], clk_neg[0]});
    end
    en[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      ph   = k % 5;
      exp3 = {ph < 3, ph == 0, ph == 3};
      nvec++;
      if ({clk_out[0], clk_pos[0], clk_neg[0]} !== exp3) begin
        nerr++;
        $display("FAIL en_restart cyc%0d got %b want %b", k,
                 {clk_out[0], clk_pos[0], clk_neg[0]}, exp3);
      end
    end
  endtask

  // Reset while running with a pending write: everything back to N=2.
  task automatic test_reset_mid();
    logic [14:0] expv;
    div_wr = 1'b1; div_sel = 3'd3; div_val = 8'd6;
    tick();
    div_wr = 1'b0;
    nvec++;
    if (busy !== 5'b01000) begin
      nerr++;
      $display("FAIL rstmid_busy_pre got %b want 01000", busy);
    end
    rst = 1'b1;
    tick();
    nvec++;
    if ({clk_out, clk_pos, clk_neg, busy, div_err} !== {5'b11111, 5'b00000, 5'b00000, 5'b00000, 1'b0}) begin
      nerr++;
      $display("FAIL rstmid_values got out=%b pos=%b neg=%b busy=%b err=%b want out=11111 pos=0 neg=0 busy=0 err=0",
               clk_out, clk_pos, clk_neg, busy, div_err);
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      expv = (k % 2 == 0) ? {5'b11111, 5'b11111, 5'b00000} : {5'b00000, 5'b00000, 5'b11111};
      nvec++;
      if ({clk_out, clk_pos, clk_neg} !== expv || busy !== 5'b00000) begin
        nerr++;
        $display("FAIL rstmid_restart cyc%0d got %b busy=%b want %b busy=00000",
                 k, {clk_out, clk_pos, clk_neg}, busy, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_div();
    test_write_mid_period();
    test_div_errors();
    test_sync_align();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
